// File: rtl/ax_arbiter_if.sv
// ax_arbiter_if: address-channel request/grant signals seen by the two-master Ax arbiter
interface ax_arbiter_if;
  logic AxVALID_M0;
  logic AxVALID_M1;
  logic AxVALID_mux;
  logic AxREADY_S;
  logic xVALID;
  logic xREADY;
  logic xLAST;
  logic gnt;
  logic AxVALID_S;
  logic AxREADY_M0;
  logic AxREADY_M1;
  logic busy;
  modport slave (
    input  AxVALID_M0, AxVALID_M1, AxVALID_mux, AxREADY_S, xVALID, xREADY, xLAST,
    output gnt, AxVALID_S, AxREADY_M0, AxREADY_M1, busy
  );
  modport master (
    output AxVALID_M0, AxVALID_M1, AxVALID_mux, AxREADY_S, xVALID, xREADY, xLAST,
    input  gnt, AxVALID_S, AxREADY_M0, AxREADY_M1, busy
  );
endinterface

// File: rtl/ax_arbiter.sv
// ax_arbiter: two-master round-robin arbiter for one AXI address channel, optionally locked until last data beat
module ax_arbiter #(
  parameter bit LOCK_DATA = 1'b1
) (
  input logic          ACLK,
  input logic          ARESETn,
  ax_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   prio_q, prio_d;
  logic   req_any, req_both, addr_hs, last_hs;
  assign req_any  = bus.AxVALID_M0 | bus.AxVALID_M1;
  assign req_both = bus.AxVALID_M0 & bus.AxVALID_M1;
  assign addr_hs  = (state_q == ADDR) & bus.AxVALID_mux & bus.AxREADY_S;
  assign last_hs  = (state_q == DATA) & bus.xVALID & bus.xREADY & bus.xLAST;
  // prio flips only when a transaction completes, handing priority to the other master
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        gnt_d   = req_any ? (req_both ? prio_q : bus.AxVALID_M1) : gnt_q;
        state_d = req_any ? ADDR : IDLE;
      end
      ADDR: begin
        state_d = addr_hs ? (LOCK_DATA ? DATA : IDLE) : ADDR;
        prio_d  = (addr_hs & !LOCK_DATA) ? ~gnt_q : prio_q;
      end
      DATA: begin
        state_d = last_hs ? IDLE : DATA;
        prio_d  = last_hs ? ~gnt_q : prio_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end
  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.AxVALID_S  = (state_q == ADDR) & bus.AxVALID_mux;
  assign bus.AxREADY_M0 = (state_q == ADDR) & ~gnt_q & bus.AxREADY_S;
  assign bus.AxREADY_M1 = (state_q == ADDR) &  gnt_q & bus.AxREADY_S;
endmodule

// File: tb/tb_ax_arbiter.sv
// tb_ax_arbiter: directed scenarios plus random traffic on both LOCK_DATA variants against a transaction-level model
module tb_ax_arbiter;
  logic clk = 1'b0;
  logic rstn, m0, m1, ardy, xv, xr, xl;
  int   tests = 0;
  int   fails = 0;
  bit   act  [2] = '{1'b0, 1'b0};
  bit   own  [2] = '{1'b0, 1'b0};
  bit   adone[2] = '{1'b0, 1'b0};
  bit   prio [2] = '{1'b0, 1'b0};
  always #5 clk = ~clk;
  ax_arbiter_if bus0();
  ax_arbiter_if bus1();
  assign bus0.AxVALID_M0  = m0;
  assign bus0.AxVALID_M1  = m1;
  assign bus0.AxVALID_mux = bus0.gnt ? m1 : m0;
  assign bus0.AxREADY_S   = ardy;
  assign bus0.xVALID      = xv;
  assign bus0.xREADY      = xr;
  assign bus0.xLAST       = xl;
  assign bus1.AxVALID_M0  = m0;
  assign bus1.AxVALID_M1  = m1;
  assign bus1.AxVALID_mux = bus1.gnt ? m1 : m0;
  assign bus1.AxREADY_S   = ardy;
  assign bus1.xVALID      = xv;
  assign bus1.xREADY      = xr;
  assign bus1.xLAST       = xl;
  ax_arbiter #(.LOCK_DATA(1'b0)) u_l0 (.ACLK(clk), .ARESETn(rstn), .bus(bus0.slave));
  ax_arbiter #(.LOCK_DATA(1'b1)) u_l1 (.ACLK(clk), .ARESETn(rstn), .bus(bus1.slave));
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // Expected outputs: a transaction is open (busy) from grant to completion; address phase is its first part
  task automatic check_models();
    for (int k = 0; k < 2; k++) begin
      bit in_addr = act[k] && !adone[k];
      bit req_sel = own[k] ? m1 : m0;
      chk($sformatf("L%0d_busy", k), k ? bus1.busy : bus0.busy, act[k]);
      chk($sformatf("L%0d_gnt", k), k ? bus1.gnt : bus0.gnt, own[k]);
      chk($sformatf("L%0d_vs", k), k ? bus1.AxVALID_S : bus0.AxVALID_S, in_addr && req_sel);
      chk($sformatf("L%0d_rdy0", k), k ? bus1.AxREADY_M0 : bus0.AxREADY_M0, in_addr && !own[k] && ardy);
      chk($sformatf("L%0d_rdy1", k), k ? bus1.AxREADY_M1 : bus0.AxREADY_M1, in_addr && own[k] && ardy);
    end
  endtask
  task automatic update_models();
    for (int k = 0; k < 2; k++) begin
      bit req_sel = own[k] ? m1 : m0;
      if (!rstn) begin
        act[k] = 0; own[k] = 0; adone[k] = 0; prio[k] = 0;
      end else if (!act[k]) begin
        if (m0 || m1) begin
          own[k]   = (m0 && m1) ? prio[k] : m1;
          act[k]   = 1;
          adone[k] = 0;
        end
      end else if (!adone[k]) begin
        if (req_sel && ardy) begin
          if (k == 1) adone[k] = 1;
          else begin act[k] = 0; prio[k] = !own[k]; end
        end
      end else if (xv && xr && xl) begin
        act[k]  = 0;
        prio[k] = !own[k];
      end
    end
  endtask
  task automatic cyc(input logic r, a0, a1, ar, v, rd, l);
    rstn = r; m0 = a0; m1 = a1; ardy = ar; xv = v; xr = rd; xl = l;
    @(negedge clk);
    check_models();
    update_models();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rstn = 0; m0 = 0; m1 = 0; ardy = 0; xv = 0; xr = 0; xl = 0;
    @(posedge clk);
    #1;
    // reset held with both masters requesting
    cyc(0, 1, 1, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 1, 1, 1);
    chk("t1_gnt", bus1.gnt, 1'b0);
    chk("t1_busy", bus1.busy, 1'b0);
    chk("t1_vs", bus1.AxVALID_S, 1'b0);
    // lone M1 request
    cyc(1, 0, 1, 1, 0, 0, 0);
    chk("t2_gnt", bus1.gnt, 1'b1);
    chk("t2_vs", bus1.AxVALID_S, 1'b1);
    chk("t2_rdy1", bus1.AxREADY_M1, 1'b1);
    chk("t2_rdy0", bus1.AxREADY_M0, 1'b0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 1);
    chk("t2_done", bus1.busy, 1'b0);
    // contention with 4-beat bursts: grants alternate
    for (int t = 0; t < 4; t++) begin
      cyc(1, 1, 1, 1, 1, 1, 0);
      chk($sformatf("t3_gnt%0d", t), bus1.gnt, logic'(t % 2));
      cyc(1, 1, 1, 1, 1, 1, 0);
      for (int b = 1; b <= 4; b++) begin
        cyc(1, 1, 1, 1, 1, 1, logic'(b == 4));
        chk($sformatf("t3_hold%0d_%0d", t, b), bus1.gnt, logic'(t % 2));
      end
    end
    // slave stall while M1 toggles
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("t4_gnt", bus1.gnt, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, logic'(i % 2), 0, 0, 0, 0);
      chk($sformatf("t4_stall_gnt%0d", i), bus1.gnt, 1'b0);
      chk($sformatf("t4_stall_vs%0d", i), bus1.AxVALID_S, 1'b1);
    end
    cyc(1, 1, 1, 1, 0, 0, 0);
    chk("t4_data", bus1.AxVALID_S, 1'b0);
    chk("t4_busy", bus1.busy, 1'b1);
    cyc(1, 0, 0, 0, 1, 1, 1);
    // LOCK_DATA=0 variant under contention
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      cyc(1, 1, 1, 1, 1, 1, 1);
      chk($sformatf("t5_gnt%0d", t), bus0.gnt, logic'(t % 2));
      cyc(1, 1, 1, 1, 1, 1, 1);
      chk($sformatf("t5_idle%0d", t), bus0.busy, 1'b0);
    end
    // reset mid-burst
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 1);
    cyc(1, 0, 1, 1, 0, 0, 0);
    chk("t6_gnt1", bus1.gnt, 1'b1);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t6_busy", bus1.busy, 1'b0);
    chk("t6_gnt", bus1.gnt, 1'b0);
    cyc(1, 0, 0, 0, 1, 1, 1);
    chk("t6_late_last", bus1.busy, 1'b0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    chk("t6_prio", bus1.gnt, 1'b0);
    // random traffic
    for (int i = 0; i < 2000; i++)
      cyc(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 3) == 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
